// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response handshake plus the data_mem pins of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_valid;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout, mem_valid,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_re, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout, mem_valid,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_re, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store front end for a word-wide data_mem with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of ignoring the low bits.
module load_store_unit #(
    parameter int ADDRW = 10
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2, RESP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;

    logic        bad_funct3, misalign, out_of_range, fault, word_store;
    logic [4:0]  bsh, hsh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val, merge_val;

    always_comb begin
        bad_funct3   = bus.req_we ? (bus.req_funct3 > 3'd2)
                                  : (bus.req_funct3 == 3'd3 || bus.req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign     = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
        misalign     = 1'b0;
`endif
        out_of_range = (bus.req_addr >> (ADDRW + 2)) != '0;
        fault        = bad_funct3 || misalign || out_of_range;
        word_store   = bus.req_we && bus.req_funct3 == 3'b010;
    end

    // Halfword lanes use only off_q[1], so unaligned H/W accesses fold onto their natural lane.
    assign bsh    = {off_q, 3'b000};
    assign hsh    = {off_q[1], 4'b0000};
    assign lane_b = 8'(bus.mem_dout >> bsh);
    assign lane_h = 16'(bus.mem_dout >> hsh);

    assign load_val  = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & lane_b[7]}}, lane_b}
                     : funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & lane_h[15]}}, lane_h}
                     : bus.mem_dout;
    assign merge_val = funct3_q[0]
        ? (bus.mem_dout & ~(32'h0000_FFFF << hsh)) | ({16'h0000, wdata_q} << hsh)
        : (bus.mem_dout & ~(32'h0000_00FF << bsh)) | ({24'h000000, wdata_q[7:0]} << bsh);

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                we_d     = bus.req_we;
                funct3_d = bus.req_funct3;
                off_d    = bus.req_addr[1:0];
                wdata_d  = bus.req_wdata[15:0];
                if (fault) begin
                    resp_fault_d = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = RESP;
                end else begin
                    mem_addr_d = {{(32 - ADDRW){1'b0}}, bus.req_addr[ADDRW+1:2]};
                    mem_din_d  = bus.req_wdata;
                    mem_we_d   = word_store;
                    mem_re_d   = !word_store;
                    state_d    = word_store ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT: if (bus.mem_valid) begin
                if (we_q) begin
                    mem_din_d = merge_val;
                    mem_we_d  = 1'b1;
                    state_d   = WR_WAIT;
                end else begin
                    resp_rdata_d = load_val;
                    resp_fault_d = 1'b0;
                    state_d      = RESP;
                end
            end
            WR_WAIT: if (bus.mem_valid) begin
                resp_rdata_d = '0;
                resp_fault_d = 1'b0;
                state_d      = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized requests against a byte-lane reference model and a one-cycle data_mem.
module tb_load_store_unit;
    localparam int ADDRW = 10;
    localparam int NW    = 1 << ADDRW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    load_store_unit_if bus();
    load_store_unit #(.ADDRW(ADDRW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        fault;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] mem [NW];
    logic [31:0] ref_mem [NW];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_re_cyc = -1;
    int          exp_we_cyc = -1;
    int          acc_cyc = 0;
    int          last_lat = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_din = '0;
    logic [31:0] hold_rdata = '0;
    logic        hold_fault = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_fault = 1'b0;
    logic [31:0] last_wr_addr = '0;
    logic        chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: works on byte lanes of the word rather than on shifted masks.
    function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic bad;
        logic mis;
        bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (int'(addr[1:0]) % (1 << f3[1:0])) != 0;
`endif
        return bad || mis || (addr >= 32'(4 * NW));
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] addr);
        int nb;
        nb = 1 << f3[1:0];
        return (int'(addr[1:0]) / nb) * nb;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        int          nb;
        int          off;
        logic [31:0] v;
        nb  = 1 << f3[1:0];
        off = lane_off(f3, addr);
        v   = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (!f3[2] && v[8*nb-1]) for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] addr,
                                                input logic [31:0] word, input logic [31:0] wdata);
        int          nb;
        int          off;
        logic [31:0] v;
        nb  = 1 << f3[1:0];
        off = lane_off(f3, addr);
        v   = word;
        for (int i = 0; i < nb; i++) v[8*(off+i) +: 8] = wdata[8*i +: 8];
        return v;
    endfunction

    // data_mem stand-in: answers a re/we pulse with mem_valid in the following cycle.
    initial begin
        logic              pr;
        logic              pw;
        logic [ADDRW-1:0]  pa;
        logic [31:0]       pd;
        bus.mem_valid = 1'b0;
        bus.mem_dout  = '0;
        forever begin
            @(negedge clk);
            pr = bus.mem_re;
            pw = bus.mem_we;
            pa = bus.mem_addr[ADDRW-1:0];
            pd = bus.mem_din;
            if (pw) last_wr_addr = bus.mem_addr;
            @(posedge clk);
            #1;
            bus.mem_valid = pr || pw;
            bus.mem_dout  = pr ? mem[pa] : $urandom;
            if (pw) mem[pa] = pd;
        end
    end

    initial begin
        logic ev;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ev = exp_q.size() != 0 && exp_q[0].cyc == cyc;
                check1("resp_valid", bus.resp_valid, ev);
                check1("req_ready", bus.req_ready, exp_q.size() == 0);
                check1("mem_re", bus.mem_re, cyc == exp_re_cyc);
                check1("mem_we", bus.mem_we, cyc == exp_we_cyc);
                if (cyc == exp_re_cyc || cyc == exp_we_cyc) check("mem_addr", bus.mem_addr, exp_addr);
                if (cyc == exp_we_cyc) check("mem_din", bus.mem_din, exp_din);
                if (ev) begin
                    hold_rdata = exp_q[0].rdata;
                    hold_fault = exp_q[0].fault;
                    last_rdata = bus.resp_rdata;
                    last_fault = bus.resp_fault;
                    last_lat   = cyc - acc_cyc;
                    void'(exp_q.pop_front());
                end
                check("resp_rdata", bus.resp_rdata, hold_rdata);
                check1("resp_fault", bus.resp_fault, hold_fault);
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int    n;
        int    a;
        int    w;
        logic  flt;
        resp_t r;
        n = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check1("accept_timeout", bus.req_ready, 1'b1);
            bus.req_valid = 1'b0;
            return;
        end
        a = cyc;
        @(posedge clk);
        w       = int'(addr[ADDRW+1:2]);
        flt     = model_fault(we, f3, addr);
        r.cyc   = a + (flt ? 1 : (we && f3 != 3'd2) ? 5 : 3);
        r.fault = flt;
        r.rdata = (flt || we) ? 32'h0 : model_load(f3, addr, ref_mem[w]);
        exp_q.push_back(r);
        acc_cyc    = a;
        exp_addr   = 32'(w);
        exp_re_cyc = (!flt && !(we && f3 == 3'd2)) ? a + 1 : -1;
        exp_we_cyc = (flt || !we) ? -1 : (f3 == 3'd2) ? a + 1 : a + 3;
        if (we && !flt) begin
            exp_din    = model_store(f3, addr, ref_mem[w], wdata);
            ref_mem[w] = exp_din;
        end
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic wait_resp;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check1("resp_timeout", bus.resp_valid, 1'b1);
            exp_q.delete();
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        send(we, f3, addr, wdata);
        wait_resp();
    endtask

    task automatic expect_resp(input string nm, input int lat, input logic flt, input logic [31:0] rd);
        check({nm, "_latency"}, 32'(last_lat), 32'(lat));
        check1({nm, "_fault"}, last_fault, flt);
        check({nm, "_rdata"}, last_rdata, rd);
    endtask

    // Pulse reset k cycles after accept; the in-flight request must vanish without a response or write.
    task automatic reset_mid(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int k);
        int          w;
        logic [31:0] saved;
        w     = int'(addr[ADDRW+1:2]);
        saved = ref_mem[w];
        send(we, f3, addr, wdata);
        repeat (k) @(negedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_re_cyc = -1;
        exp_we_cyc = -1;
        hold_rdata = '0;
        hold_fault = 1'b0;
        ref_mem[w] = saved;
        #1;
        check1("rst_mem_re", bus.mem_re, 1'b0);
        check1("rst_mem_we", bus.mem_we, 1'b0);
        check1("rst_req_ready", bus.req_ready, 1'b1);
        check1("rst_resp_valid", bus.resp_valid, 1'b0);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] ad;
        for (int i = 0; i < NW; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        #1 rst = 1'b0;
        #2;
        check1("reset_req_ready", bus.req_ready, 1'b1);
        check1("reset_resp_valid", bus.resp_valid, 1'b0);
        check("reset_resp_rdata", bus.resp_rdata, 32'h0);
        check1("reset_resp_fault", bus.resp_fault, 1'b0);
        check1("reset_mem_re", bus.mem_re, 1'b0);
        check1("reset_mem_we", bus.mem_we, 1'b0);
        check("reset_mem_addr", bus.mem_addr, 32'h0);
        check("reset_mem_din", bus.mem_din, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;

        check("model_lb", model_load(3'b000, 32'h23, 32'h80FF7F01), 32'hFFFFFF80);
        check("model_lhu", model_load(3'b101, 32'h22, 32'h80FF7F01), 32'h000080FF);
        check("model_sb", model_store(3'b000, 32'h31, 32'h11223344, 32'h000000AB), 32'h1122AB44);

        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        expect_resp("sw", 3, 1'b0, 32'h0);
        check("sw_mem_addr", last_wr_addr, 32'h4);
        txn(1'b0, 3'b010, 32'h10, 32'h0);
        expect_resp("lw", 3, 1'b0, 32'hDEADBEEF);

        txn(1'b1, 3'b010, 32'h20, 32'h80FF7F01);
        txn(1'b0, 3'b000, 32'h23, 32'h0);
        expect_resp("lb23", 3, 1'b0, 32'hFFFFFF80);
        txn(1'b0, 3'b100, 32'h23, 32'h0);
        expect_resp("lbu23", 3, 1'b0, 32'h00000080);
        txn(1'b0, 3'b000, 32'h21, 32'h0);
        expect_resp("lb21", 3, 1'b0, 32'h0000007F);
        txn(1'b0, 3'b001, 32'h22, 32'h0);
        expect_resp("lh22", 3, 1'b0, 32'hFFFF80FF);
        txn(1'b0, 3'b101, 32'h20, 32'h0);
        expect_resp("lhu20", 3, 1'b0, 32'h00007F01);

        txn(1'b1, 3'b010, 32'h30, 32'h11223344);
        txn(1'b1, 3'b000, 32'h31, 32'hFFFFFFAB);
        expect_resp("sb31", 5, 1'b0, 32'h0);
        txn(1'b0, 3'b010, 32'h30, 32'h0);
        expect_resp("lw30", 3, 1'b0, 32'h1122AB44);

        txn(1'b0, 3'b010, 32'h32, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        expect_resp("lw32_misaligned", 1, 1'b1, 32'h0);
`else
        expect_resp("lw32_misaligned", 3, 1'b0, 32'h1122AB44);
`endif
        txn(1'b0, 3'b011, 32'h30, 32'h0);
        expect_resp("ld_illegal", 1, 1'b1, 32'h0);
        txn(1'b0, 3'b010, 32'h1000, 32'h0);
        expect_resp("lw_out_of_range", 1, 1'b1, 32'h0);
        txn(1'b1, 3'b100, 32'h30, 32'h0);
        expect_resp("st_illegal", 1, 1'b1, 32'h0);

        reset_mid(1'b0, 3'b010, 32'h30, 32'h0, 1);
        txn(1'b0, 3'b010, 32'h30, 32'h0);
        expect_resp("lw_after_reset", 3, 1'b0, 32'h1122AB44);
        reset_mid(1'b1, 3'b000, 32'h30, 32'h55, 2);
        txn(1'b0, 3'b010, 32'h30, 32'h0);
        expect_resp("lw_after_rmw_abort", 3, 1'b0, 32'h1122AB44);

        for (int i = 0; i < 400; i++) begin
            ad = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) ad = $urandom;
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ad, $urandom);
            repeat ($urandom_range(0, 1)) @(posedge clk);
        end
        wait_resp();
        repeat (3) @(posedge clk);

        n = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) n++;
        check("mem_image_mismatches", 32'(n), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
